// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and axis phase encoding for the VGA timing generator.
package vga_timing_pkg;

    // Counter / coordinate width shared by both axes and the x/y ports.
    localparam int unsigned CNT_W = 10;

    // 640x480 @ 60 Hz industry timing, in pixel steps (h) and lines (v).
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Phase of one scan axis. The horizontal instance walks
    // H_ACT/H_FRONT/H_SYNCP/H_BACK and the vertical one V_ACT/V_FRONT/V_SYNCP/V_BACK;
    // both use this common encoding.
    typedef enum logic [1:0] {
        AX_ACT   = 2'd0,
        AX_FRONT = 2'd1,
        AX_SYNCP = 2'd2,
        AX_BACK  = 2'd3
    } axis_state_e;

    typedef axis_state_e h_state_e;
    typedef axis_state_e v_state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: position counter plus active/front/sync/back phase FSM.
// 'step' advances the axis by one position; 'wrap' flags the step that
// returns the counter from TOTAL-1 to 0. in_active/in_sync and cnt_nxt
// describe the position the axis holds after the current clock edge, so the
// parent can register them together with the counter.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             wrap,
    output logic             in_active,
    output logic             in_sync
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] END_ACT   = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FRONT = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] END_SYNC  = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] END_BACK  = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt;
    axis_state_e      state;
    axis_state_e      state_nxt;
    logic             at_end;

    assign at_end = (cnt == END_BACK);
    assign wrap   = step & at_end;

    // Counter and phase register; reset parks the axis on its last position
    // so the first step lands on position 0 in the active phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= END_BACK;
            state <= AX_BACK;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
        end
    end

    // Next position and next phase; the phase leaves each region on its last count.
    always_comb begin
        cnt_nxt   = cnt;
        state_nxt = state;
        if (step) begin
            cnt_nxt = at_end ? '0 : cnt + 1'b1;
            case (state)
                AX_ACT:   if (cnt == END_ACT)   state_nxt = AX_FRONT;
                AX_FRONT: if (cnt == END_FRONT) state_nxt = AX_SYNCP;
                AX_SYNCP: if (cnt == END_SYNC)  state_nxt = AX_BACK;
                AX_BACK:  if (cnt == END_BACK)  state_nxt = AX_ACT;
                default:                        state_nxt = AX_BACK;
            endcase
        end
    end

    assign in_active = (state_nxt == AX_ACT);
    assign in_sync   = (state_nxt == AX_SYNCP);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync pulses, blanking
// and a once-per-frame tick at the start of vertical blank.
// Build option VGA_PIX_DIV_EN: clk runs at twice the pixel rate and an
// internal 1-bit divider produces pix_en / VGA_CLK. Without it clk is the
// pixel clock and every clk after reset is a pixel step.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active_pixels,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic             VGA_CLK,
    output logic             pix_en,
    output logic             frame_tick
);

    localparam logic [CNT_W-1:0] V_BLANK_START = CNT_W'(V_ACTIVE);

    logic             step;
    logic [CNT_W-1:0] h_cnt_nxt;
    logic [CNT_W-1:0] v_cnt_nxt;
    logic             h_wrap;
    logic             v_wrap_unused;
    logic             h_active;
    logic             v_active;
    logic             h_sync;
    logic             v_sync;
    logic             frame_hit;

`ifdef VGA_PIX_DIV_EN
    logic phase;

    // Divide-by-two phase; edges where it is high are pixel steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    assign step    = phase;
    assign VGA_CLK = phase;
`else
    assign step    = 1'b1;
    // Held low in reset so the DAC sees no clock while the raster is parked.
    assign VGA_CLK = rst_n & ~clk;
`endif

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step),
        .cnt_nxt   (h_cnt_nxt),
        .wrap      (h_wrap),
        .in_active (h_active),
        .in_sync   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (h_wrap),
        .cnt_nxt   (v_cnt_nxt),
        .wrap      (v_wrap_unused),
        .in_active (v_active),
        .in_sync   (v_sync)
    );

    // Line wrap that moves the vertical count onto the first blank line.
    assign frame_hit = h_wrap & (v_cnt_nxt == V_BLANK_START);

    // Registered outputs, refreshed on every pixel step; the strobes are
    // re-evaluated every clk so they last exactly one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x             <= '0;
            y             <= '0;
            active_pixels <= 1'b0;
            VGA_HS        <= 1'b1;
            VGA_VS        <= 1'b1;
            pix_en        <= 1'b0;
            frame_tick    <= 1'b0;
        end else begin
            pix_en     <= step;
            frame_tick <= frame_hit;
            if (step) begin
                x             <= h_cnt_nxt;
                y             <= v_cnt_nxt;
                active_pixels <= h_active & v_active;
                VGA_HS        <= ~h_sync;
                VGA_VS        <= ~v_sync;
            end
        end
    end

    assign VGA_BLANK_N = active_pixels;
    assign VGA_SYNC_N  = 1'b0;

endmodule
